branch_target_unit: RTL

//  Next-generation PC-target logic: resolves branch/JAL/JALR targets in Execute and predicts the next PC in Fetch.

---
 rtl/branch_target_unit.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/branch_target_unit.sv
// Branch target unit: resolves control-flow targets in Execute and predicts the next Fetch PC
// from a direct-mapped BTB with 2-bit counters plus a circular return-address stack.
module branch_target_unit #(
    parameter int DATA_WIDTH  = 32,
    parameter int BTB_ENTRIES = 16,
    parameter int RAS_DEPTH   = 4,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] PCF,
    output logic                  PredTakenF,
    output logic [DATA_WIDTH-1:0] PredTargetF,
    input  logic                  ValidE,
    input  logic [DATA_WIDTH-1:0] PCE,
    input  logic [DATA_WIDTH-1:0] ImmExtE,
    input  logic [DATA_WIDTH-1:0] ALUResultE,
    input  logic                  BranchE,
    input  logic                  JumpE,
    input  logic                  JALRE,
    input  logic                  CondE,
    input  logic                  CallE,
    input  logic                  RetE,
    input  logic                  PredTakenE,
    input  logic [DATA_WIDTH-1:0] PredTargetE,
    output logic [DATA_WIDTH-1:0] PCTargetE,
    output logic                  RedirectE,
    output logic [DATA_WIDTH-1:0] RedirectPCE,
    output logic [CNT_WIDTH-1:0]  BranchCount,
    output logic [CNT_WIDTH-1:0]  MispredictCount
);
    localparam int IDX   = $clog2(BTB_ENTRIES);
    localparam int TAG_W = DATA_WIDTH - IDX - 2;
    localparam int RAS_W = $clog2(RAS_DEPTH);

    logic [BTB_ENTRIES-1:0] r_valid;
    logic [BTB_ENTRIES-1:0] r_is_ret;
    logic [BTB_ENTRIES-1:0] r_is_jump;
    logic [1:0]             r_ctr    [BTB_ENTRIES];
    logic [TAG_W-1:0]       r_tag    [BTB_ENTRIES];
    logic [DATA_WIDTH-1:0]  r_target [BTB_ENTRIES];

    logic [DATA_WIDTH-1:0]  r_ras [RAS_DEPTH];
    logic [RAS_W-1:0]       r_ras_ptr;
    logic [RAS_W:0]         r_ras_count;

    logic [CNT_WIDTH-1:0]   r_branch_cnt;
    logic [CNT_WIDTH-1:0]   r_mispred_cnt;

    logic [IDX-1:0]         w_idx_f, w_idx_e;
    logic [TAG_W-1:0]       w_tag_f, w_tag_e;
    logic                   w_hit_f, w_hit_e;
    logic [RAS_W-1:0]       w_ras_top_idx, w_ras_wr_idx;
    logic                   w_ras_empty, w_push, w_pop;
    logic                   w_taken_e;
    logic [DATA_WIDTH-1:0]  w_pc_plus4_e;

    assign w_idx_f       = PCF[IDX+1:2];
    assign w_tag_f       = PCF[DATA_WIDTH-1:IDX+2];
    assign w_hit_f       = r_valid[w_idx_f] && (r_tag[w_idx_f] == w_tag_f);
    assign w_ras_top_idx = r_ras_ptr - RAS_W'(1);
    assign w_ras_empty   = (r_ras_count == '0);

    // Fetch prediction reads registered state only, so a same-cycle update is seen next cycle.
    // NOTE: every output gets a default first so no path through the branches can infer a latch.
    always_comb begin
        PredTakenF  = 1'b0;
        PredTargetF = PCF + DATA_WIDTH'(4);
        if (w_hit_f) begin
            if (r_is_ret[w_idx_f]) begin
                if (!w_ras_empty) begin
                    PredTakenF  = 1'b1;
                    PredTargetF = r_ras[w_ras_top_idx];
                end
            end else if (r_is_jump[w_idx_f] || r_ctr[w_idx_f][1]) begin
                PredTakenF  = 1'b1;
                PredTargetF = r_target[w_idx_f];
            end
        end
    end

    assign w_pc_plus4_e = PCE + DATA_WIDTH'(4);
    assign PCTargetE    = JALRE ? (ALUResultE & ~DATA_WIDTH'(1)) : (PCE + ImmExtE);
    assign w_taken_e    = ValidE & (JumpE | JALRE | (BranchE & CondE));
    assign RedirectE    = ValidE & ((PredTakenE != w_taken_e) |
                                    (w_taken_e & (PredTargetE != PCTargetE)));
    assign RedirectPCE  = w_taken_e ? PCTargetE : w_pc_plus4_e;

    assign w_idx_e = PCE[IDX+1:2];
    assign w_tag_e = PCE[DATA_WIDTH-1:IDX+2];
    assign w_hit_e = r_valid[w_idx_e] && (r_tag[w_idx_e] == w_tag_e);

    // NOTE: only the control bits (valid, ctr, flags) are reset; tag/target storage is masked by
    // valid, so it lives in a reset-free block and can map onto plain RAM.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid   <= '0;
            r_is_ret  <= '0;
            r_is_jump <= '0;
            for (int i = 0; i < BTB_ENTRIES; i++) r_ctr[i] <= 2'b00;
        end else if (w_taken_e) begin
            r_valid[w_idx_e]   <= 1'b1;
            r_is_ret[w_idx_e]  <= RetE;
            r_is_jump[w_idx_e] <= JumpE | JALRE;
            if (!w_hit_e)                    r_ctr[w_idx_e] <= 2'b10;
            else if (r_ctr[w_idx_e] != 2'b11) r_ctr[w_idx_e] <= r_ctr[w_idx_e] + 2'd1;
        end else if (ValidE && BranchE && w_hit_e && r_ctr[w_idx_e] != 2'b00) begin
            r_ctr[w_idx_e] <= r_ctr[w_idx_e] - 2'd1;
        end
    end

    // NOTE: sequential state always uses non-blocking assignments so every block samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst && w_taken_e) begin
            r_tag[w_idx_e]    <= w_tag_e;
            r_target[w_idx_e] <= PCTargetE;
        end
    end

    // Call+return in one instruction overwrites the top in place; a pop on empty is ignored.
    assign w_push       = ValidE & CallE;
    assign w_pop        = ValidE & RetE & !w_ras_empty;
    assign w_ras_wr_idx = w_pop ? w_ras_top_idx : r_ras_ptr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ras_ptr   <= '0;
            r_ras_count <= '0;
        end else if (w_push && !w_pop) begin
            r_ras_ptr <= r_ras_ptr + RAS_W'(1);
            if (r_ras_count != (RAS_W+1)'(RAS_DEPTH)) r_ras_count <= r_ras_count + (RAS_W+1)'(1);
        end else if (w_pop && !w_push) begin
            r_ras_ptr   <= w_ras_top_idx;
            r_ras_count <= r_ras_count - (RAS_W+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && w_push) r_ras[w_ras_wr_idx] <= w_pc_plus4_e;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_branch_cnt  <= '0;
            r_mispred_cnt <= '0;
        end else begin
            if (ValidE && (BranchE || JumpE || JALRE) && r_branch_cnt != '1)
                r_branch_cnt <= r_branch_cnt + CNT_WIDTH'(1);
            if (RedirectE && r_mispred_cnt != '1)
                r_mispred_cnt <= r_mispred_cnt + CNT_WIDTH'(1);
        end
    end

    assign BranchCount     = r_branch_cnt;
    assign MispredictCount = r_mispred_cnt;
endmodule
